// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the 4-phase req/ack CDC handshake blocks.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    WAIT_ACC = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // True when a synchronizer depth is within the supported range.
  function automatic bit sync_stages_ok(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit level synchronizer: SYNC_STAGES flops, async active-low reset to 0.
// Shared between the handshake receiver (req) and transmitter (ack).
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination endpoint of the 4-phase req/ack CDC handshake.
// Synchronizes req, captures the bundled data word once it is known stable,
// offers it on a valid/ready port and returns ack as a registered level.
// Optional build macro: CDC_HS_RX_PARITY_CHK_EN adds par_async/par_err.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   IDLE     | no transfer; waiting for synchronized req high
//   CAPTURE  | one cycle; sample data_async into dout, raise valid
//   WAIT_ACC | word offered; waiting for dout_ready
//   WAIT_REL | ack high; waiting for synchronized req low
module cdc_hs_rx
  import cdc_hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_async,
  input  logic [DATA_W-1:0] data_async,
  output logic              ack,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
`ifdef CDC_HS_RX_PARITY_CHK_EN
  ,
  input  logic              par_async,
  output logic              par_err
`endif
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("cdc_hs_rx: SYNC_STAGES out of range 2..4");
  end

  state_t state;
  state_t state_next;
  logic   req_s;
  logic   capture_en;
  logic   accept_en;
  logic   release_en;

  cdc_sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_async),
    .q     (req_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath strobes. A req drop seen in WAIT_ACC is
  // deliberately ignored: the word must still be accepted before WAIT_REL.
  always_comb begin
    state_next = state;
    capture_en = 1'b0;
    accept_en  = 1'b0;
    release_en = 1'b0;
    case (state)
      IDLE: begin
        if (req_s) state_next = CAPTURE;
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_next = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (dout_valid && dout_ready) begin
          accept_en  = 1'b1;
          state_next = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!req_s) begin
          release_en = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output word register; data_async is only sampled in CAPTURE, where the
  // bundled-data rule guarantees it has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (capture_en) begin
      dout       <= data_async;
      dout_valid <= 1'b1;
    end else if (accept_en) begin
      dout_valid <= 1'b0;
    end
  end

  // Ack level back to the source; a bare flop so it can cross cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0;
    end else if (accept_en) begin
      ack <= 1'b1;
    end else if (release_en) begin
      ack <= 1'b0;
    end
  end

`ifdef CDC_HS_RX_PARITY_CHK_EN
  // Even-parity check of the captured word; held until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
    end else if (capture_en) begin
      par_err <= (^data_async) ^ par_async;
    end
  end
`endif

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Self-checking bench for cdc_hs_rx: scoreboard of words pushed at send time
// and popped when the consumer port accepts them.
module tb_cdc_hs_rx;

  localparam int DW = 8;
  localparam int SYNC3 = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_async;
  logic [DW-1:0] data_async;
  logic          ack;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  logic          req3;
  logic [DW-1:0] data3;
  logic          ack3;
  logic [DW-1:0] dout3;
  logic          dout_valid3;
  logic          ready3;

`ifdef CDC_HS_RX_PARITY_CHK_EN
  logic par_async;
  logic par_err;
  logic par_err3;
`endif

  int checks   = 0;
  int failures = 0;
  int accepts  = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  cdc_hs_rx #(.DATA_W(DW), .SYNC_STAGES(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_async  (req_async),
    .data_async (data_async),
    .ack        (ack),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef CDC_HS_RX_PARITY_CHK_EN
    ,
    .par_async  (par_async),
    .par_err    (par_err)
`endif
  );

  cdc_hs_rx #(.DATA_W(DW), .SYNC_STAGES(SYNC3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_async  (req3),
    .data_async (data3),
    .ack        (ack3),
    .dout       (dout3),
    .dout_valid (dout_valid3),
    .dout_ready (ready3)
`ifdef CDC_HS_RX_PARITY_CHK_EN
    ,
    .par_async  (1'b0),
    .par_err    (par_err3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (ack !== lvl && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(ack), 32'(lvl));
  endtask

  // Behavioural source: present word, raise req, full 4-phase round trip.
  task automatic send_word(input logic [DW-1:0] d, input logic p);
    data_async = d;
`ifdef CDC_HS_RX_PARITY_CHK_EN
    par_async = p;
`else
    if (p) data_async = d;
`endif
    sb_q.push_back(d);
    req_async = 1'b1;
    wait_ack(1'b1, 40, "ack_rise");
    req_async = 1'b0;
    wait_ack(1'b0, 40, "ack_fall");
    tick(1);
  endtask

  // Consumer-side monitor: an accept happens at the posedge after this sample.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      logic [DW-1:0] exp_w;
      chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        chk("sb_data", 32'(dout), 32'(exp_w));
      end
      accepts++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n;
    rst_n      = 1'b0;
    req_async  = 1'b0;
    data_async = '0;
    dout_ready = 1'b0;
    req3       = 1'b0;
    data3      = '0;
    ready3     = 1'b1;
`ifdef CDC_HS_RX_PARITY_CHK_EN
    par_async  = 1'b0;
`endif
    tick(3);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_ack",   32'(ack), 0);
    chk("rst_dout",  32'(dout), 0);
    rst_n = 1'b1;
    tick(2);

    // Basic transfer: valid 4 edges after req (2 sync + 2), ack one later.
    dout_ready = 1'b1;
    data_async = 8'hA5;
    sb_q.push_back(8'hA5);
    req_async = 1'b1;
    tick(3);
    chk("basic_valid_early", 32'(dout_valid), 0);
    tick(1);
    chk("basic_valid", 32'(dout_valid), 1);
    chk("basic_dout", 32'(dout), 32'hA5);
    chk("basic_ack_early", 32'(ack), 0);
    tick(1);
    chk("basic_ack", 32'(ack), 1);
    chk("basic_valid_drop", 32'(dout_valid), 0);
    req_async = 1'b0;
    tick(2);
    chk("basic_ack_hold", 32'(ack), 1);
    tick(1);
    chk("basic_ack_fall", 32'(ack), 0);
    tick(2);

    // Backpressure: word held with ack low until the consumer is ready.
    dout_ready = 1'b0;
    data_async = 8'h3C;
    sb_q.push_back(8'h3C);
    req_async = 1'b1;
    tick(4);
    chk("bp_valid_rise", 32'(dout_valid), 1);
    tick(10);
    chk("bp_valid_hold", 32'(dout_valid), 1);
    chk("bp_dout_hold", 32'(dout), 32'h3C);
    chk("bp_ack_low", 32'(ack), 0);
    dout_ready = 1'b1;
    tick(1);
    chk("bp_ack", 32'(ack), 1);
    chk("bp_valid_drop", 32'(dout_valid), 0);
    req_async = 1'b0;
    wait_ack(1'b0, 40, "bp_ack_fall");
    tick(1);

    // Back-to-back words through the behavioural source.
    base = accepts;
    send_word(8'h01, 1'b1);
    send_word(8'h02, 1'b1);
    send_word(8'h03, 1'b0);
    chk("b2b_accepts", 32'(accepts - base), 3);

    // Reset while the word waits for acceptance; req stays high across it.
    dout_ready = 1'b0;
    data_async = 8'h5A;
    sb_q.push_back(8'h5A);
    req_async = 1'b1;
    tick(4);
    chk("rmid_valid", 32'(dout_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_valid_clr", 32'(dout_valid), 0);
    chk("rmid_ack_clr", 32'(ack), 0);
    chk("rmid_dout_clr", 32'(dout), 0);
    tick(2);
    rst_n = 1'b1;
    base = accepts;
    tick(1);
    dout_ready = 1'b1;
    wait_ack(1'b1, 40, "rmid_ack_rise");
    req_async = 1'b0;
    wait_ack(1'b0, 40, "rmid_ack_fall");
    tick(5);
    chk("rmid_recapture_once", 32'(accepts - base), 1);

`ifdef CDC_HS_RX_PARITY_CHK_EN
    send_word(8'h07, 1'b0);
    chk("par_err_set", 32'(par_err), 1);
    send_word(8'h07, 1'b1);
    chk("par_err_clr", 32'(par_err), 0);
`endif

    // Three-stage synchronizer: SYNC3 edges to req_s, then two more to valid.
    data3 = 8'hC3;
    req3  = 1'b1;
    n = 0;
    while (dout_valid3 !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    chk("sync3_latency", 32'(n), 32'(SYNC3 + 2));
    chk("sync3_dout", 32'(dout3), 32'hC3);
    req3 = 1'b0;
    tick(8);
    chk("sync3_ack_fall", 32'(ack3), 0);

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
